// File: rtl/serial_adder.sv
// Purpose : bit-serial two's-complement adder/subtractor, one bit pair per clock, LSB first.
// Latency : start accepted at edge N, result/flags valid with the done pulse after edge N+WIDTH.
// Backpressure: none; start is ignored while busy, and a start during the done cycle is accepted.
//
// Ports:
//   clk    - rising-edge clock for all state
//   rst    - synchronous active-high reset, has priority over start
//   start  - request a new operation (sampled only in IDLE or DONE)
//   a, b   - operands, two's complement, WIDTH bits
//   sub    - 0: a+b, 1: a-b
//   busy   - high for exactly WIDTH cycles while bits are processed
//   done   - one-cycle pulse when result and flags are valid
//   result - sum/difference, held until the edge after the next accepted start
//   cout   - final carry (for subtraction, 1 means no borrow)
//   ovfl   - signed overflow (carry into MSB xor carry out of MSB)
//   zero   - result == 0
//   neg    - result MSB
//
// Optional feature: define SERIAL_ADDER_SAT_EN to saturate the result on signed
// overflow instead of wrapping. Latency is the same in both builds.

// Single-bit full adder cell used by the serial datapath.
module full_adder (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (x & ci) | (y & ci);
endmodule

module serial_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovfl,
  output logic             zero,
  output logic             neg
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;

  logic             sum_bit;
  logic             carry_out;
  logic             accept;
  logic             last_bit;
  logic             ovf_bit;
  logic [WIDTH-1:0] res_shift;
  logic [WIDTH-1:0] res_fin;

  // One bit pair per cycle; operand registers shift right so bit 0 is always
  // the current pair.
  full_adder u_fa (
    .x  (a_sr[0]),
    .y  (b_sr[0]),
    .ci (carry),
    .s  (sum_bit),
    .co (carry_out)
  );

  assign accept   = start && ((state == IDLE) || (state == DONE));
  assign last_bit = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

  // Sum bits enter from the MSB side, so after WIDTH shifts bit 0 of the
  // answer sits at bit 0 of the register.
  assign res_shift = {sum_bit, res_sr[WIDTH-1:1]};

  // On the last bit the registered carry is the carry into the MSB.
  assign ovf_bit = carry ^ carry_out;

`ifdef SERIAL_ADDER_SAT_EN
  // Overflow only happens when both effective operands share a sign, so the
  // MSB of a alone tells positive from negative overflow. a_sr[0] holds that
  // MSB on the last bit.
  always_comb begin
    res_fin = res_shift;
    if (ovf_bit) begin
      if (a_sr[0]) begin
        res_fin = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        res_fin = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
  end
`else
  assign res_fin = res_shift;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt == CW'(WIDTH - 1)) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (start) begin
          state_nxt = SHIFT;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Output decode.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Datapath. res_sr and the flags are left untouched on the accepting edge so
  // the previous answer stays visible until the first shift.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      cout   <= 1'b0;
      ovfl   <= 1'b0;
      zero   <= 1'b0;
      neg    <= 1'b0;
    end else if (accept) begin
      a_sr  <= a;
      // Subtraction as a + ~b + 1: invert b here, the +1 is the preset carry.
      b_sr  <= b ^ {WIDTH{sub}};
      carry <= sub;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
      carry <= carry_out;
      cnt   <= cnt + CW'(1);
      if (last_bit) begin
        res_sr <= res_fin;
        cout   <= carry_out;
        ovfl   <= ovf_bit;
        zero   <= (res_fin == '0);
        neg    <= res_fin[WIDTH-1];
      end else begin
        res_sr <= res_shift;
      end
    end
  end

  assign result = res_sr;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: a 16-bit instance for the corner cases and
// protocol behaviour, plus a 4-bit instance swept over every a, b and sub.
module tb_serial_adder;

  logic        clk;
  logic        rst;

  logic        start16;
  logic [15:0] a16;
  logic [15:0] b16;
  logic        sub16;
  logic        busy16;
  logic        done16;
  logic [15:0] res16;
  logic        cout16;
  logic        ovfl16;
  logic        zero16;
  logic        neg16;

  logic        start4;
  logic [3:0]  a4;
  logic [3:0]  b4;
  logic        sub4;
  logic        busy4;
  logic        done4;
  logic [3:0]  res4;
  logic        cout4;
  logic        ovfl4;
  logic        zero4;
  logic        neg4;

  int total;
  int bad;

  serial_adder #(.WIDTH(16)) dut16 (
    .clk    (clk),
    .rst    (rst),
    .start  (start16),
    .a      (a16),
    .b      (b16),
    .sub    (sub16),
    .busy   (busy16),
    .done   (done16),
    .result (res16),
    .cout   (cout16),
    .ovfl   (ovfl16),
    .zero   (zero16),
    .neg    (neg16)
  );

  serial_adder #(.WIDTH(4)) dut4 (
    .clk    (clk),
    .rst    (rst),
    .start  (start4),
    .a      (a4),
    .b      (b4),
    .sub    (sub4),
    .busy   (busy4),
    .done   (done4),
    .result (res4),
    .cout   (cout4),
    .ovfl   (ovfl4),
    .zero   (zero4),
    .neg    (neg4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Launch one 16-bit operation from IDLE/DONE and follow it to the done cycle.
  // Operand inputs are scrambled after acceptance since they are don't-care.
  task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                       input logic tsub, input logic [15:0] prev_res);
    int bcnt;
    a16 = ta; b16 = tb_v; sub16 = tsub; start16 = 1'b1;
    tick();
    start16 = 1'b0; a16 = ~ta; b16 = ~tb_v; sub16 = ~tsub;
    chk({tag, ".res_held_at_accept"}, 32'(res16), 32'(prev_res));
    bcnt = 0;
    for (int k = 0; k < 16; k++) begin
      if (busy16 && !done16) bcnt++;
      tick();
    end
    chk({tag, ".busy_len"}, 32'(bcnt), 32'd16);
    chk({tag, ".busy_done"}, 32'({busy16, done16}), 32'd1);
  endtask

  task automatic chk_out(input string tag, input logic [15:0] r, input logic c,
                         input logic o, input logic z, input logic n);
    chk({tag, ".result"}, 32'(res16), 32'(r));
    chk({tag, ".cout"}, 32'(cout16), 32'(c));
    chk({tag, ".ovfl"}, 32'(ovfl16), 32'(o));
    chk({tag, ".zero"}, 32'(zero16), 32'(z));
    chk({tag, ".neg"}, 32'(neg16), 32'(n));
  endtask

  logic [15:0] exp_pos_ovf;
  logic        exp_pos_neg;
  logic [15:0] exp_neg_ovf;
  logic        exp_neg_neg;
  int          dcnt;
  int          run;
  logic        prev_done;
  logic        got_done;
  logic [3:0]  m_beff;
  logic [4:0]  m_full;
  logic [3:0]  m_res;
  logic        m_ovf;

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b1;
    start16 = 1'b0; a16 = '0; b16 = '0; sub16 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; sub4 = 1'b0;

`ifdef SERIAL_ADDER_SAT_EN
    exp_pos_ovf = 16'h7FFF; exp_pos_neg = 1'b0;
    exp_neg_ovf = 16'h8000; exp_neg_neg = 1'b1;
`else
    exp_pos_ovf = 16'h8000; exp_pos_neg = 1'b1;
    exp_neg_ovf = 16'h7FFF; exp_neg_neg = 1'b0;
`endif

    // Reset state
    tick();
    tick();
    rst = 1'b0;
    chk("rst.busy", 32'(busy16), 32'd0);
    chk("rst.done", 32'(done16), 32'd0);
    chk_out("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

    // Positive overflow: 0x7FFF + 1
    run16("pos_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h0000);
    chk_out("pos_ovf", exp_pos_ovf, 1'b0, 1'b1, 1'b0, exp_pos_neg);
    tick();
    chk("pos_ovf.done_one_cycle", 32'(done16), 32'd0);

    // 5 - 5 = 0, no borrow
    run16("sub_zero", 16'h0005, 16'h0005, 1'b1, exp_pos_ovf);
    chk_out("sub_zero", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0);
    tick();

    // 0 - 1 = -1, borrow
    run16("sub_neg", 16'h0000, 16'h0001, 1'b1, 16'h0000);
    chk_out("sub_neg", 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();

    // Negative overflow: 0x8000 - 1
    run16("neg_ovf", 16'h8000, 16'h0001, 1'b1, 16'hFFFF);
    chk_out("neg_ovf", exp_neg_ovf, 1'b1, 1'b1, 1'b0, exp_neg_neg);
    tick();
    tick();
    tick();
    chk("neg_ovf.res_hold_idle", 32'(res16), 32'(exp_neg_ovf));

    // Reset at edge N+8 of an operation aborts it with no done pulse
    a16 = 16'h1234; b16 = 16'h1111; sub16 = 1'b0; start16 = 1'b1;
    tick();
    start16 = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst.busy", 32'(busy16), 32'd0);
    chk("midrst.done", 32'(done16), 32'd0);
    chk_out("midrst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    dcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (done16) dcnt++;
      tick();
    end
    chk("midrst.no_done", 32'(dcnt), 32'd0);
    run16("after_rst", 16'h1234, 16'h1111, 1'b0, 16'h0000);
    chk_out("after_rst", 16'h2345, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();

    // Reset wins over start on the same edge
    rst = 1'b1; start16 = 1'b1;
    tick();
    rst = 1'b0; start16 = 1'b0;
    chk("rst_prio.busy", 32'(busy16), 32'd0);
    tick();
    chk("rst_prio.busy2", 32'(busy16), 32'd0);

    // start held high for 40 cycles: back-to-back operations every 17 cycles
    a16 = 16'h1234; b16 = 16'h1111; sub16 = 1'b0; start16 = 1'b1;
    dcnt = 0; run = 0; prev_done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (done16) begin
        dcnt++;
        chk("held.result", 32'(res16), 32'h2345);
        chk("held.pulse_width", 32'(prev_done), 32'd0);
      end
      if (busy16) begin
        run++;
      end else if (run != 0) begin
        chk("held.busy_len", 32'(run), 32'd16);
        run = 0;
      end
      prev_done = done16;
    end
    chk("held.done_count", 32'(dcnt), 32'd2);
    start16 = 1'b0;
    got_done = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (!got_done) begin
        tick();
        if (done16) got_done = 1'b1;
      end
    end
    chk("held.last_done", 32'(got_done), 32'd1);
    chk("held.last_result", 32'(res16), 32'h2345);

    // Exhaustive 4-bit sweep against a behavioural model
    for (int s = 0; s < 2; s++) begin
      for (int x = 0; x < 16; x++) begin
        for (int y = 0; y < 16; y++) begin
          a4 = 4'(x); b4 = 4'(y); sub4 = 1'(s); start4 = 1'b1;
          tick();
          start4 = 1'b0;
          for (int k = 0; k < 4; k++) tick();
          m_beff = (s != 0) ? ~4'(y) : 4'(y);
          m_full = {1'b0, 4'(x)} + {1'b0, m_beff} + 5'(s);
          m_ovf  = (x[3] == m_beff[3]) && (m_full[3] != x[3]);
          m_res  = m_full[3:0];
`ifdef SERIAL_ADDER_SAT_EN
          if (m_ovf) m_res = x[3] ? 4'b1000 : 4'b0111;
`endif
          chk("w4.done", 32'({busy4, done4}), 32'd1);
          chk("w4.sum", 32'({cout4, res4}), 32'({m_full[4], m_res}));
          chk("w4.ovfl", 32'(ovfl4), 32'(m_ovf));
          chk("w4.zero", 32'(zero4), 32'(m_res == 4'd0));
          chk("w4.neg", 32'(neg4), 32'(m_res[3]));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
